// File: rtl/inst_fetcher_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetcher_pkg
// Shared constants and types for the instruction fetch stage:
//   - data-path width and boolean / zero constants
//   - instruction-cache geometry helpers, derived from the line count
//   - fetch FSM state encoding
// ---------------------------------------------------------------------------
package inst_fetcher_pkg;

   localparam int                    DATA_WIDTH = 32;
   localparam logic                  TRUE       = 1'b1;
   localparam logic                  FALSE      = 1'b0;
   localparam logic [DATA_WIDTH-1:0] ZERO_DATA  = '0;

   // Default cache geometry. The index sits just above the two byte-offset
   // bits of the PC; the tag is everything above the index.
   localparam int ICACHE_LINES_DEFAULT = 256;

   function automatic int icache_idx_w(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int icache_tag_w(input int lines);
      return DATA_WIDTH - $clog2(lines) - 2;
   endfunction

   localparam int ICACHE_IDX_W = icache_idx_w(ICACHE_LINES_DEFAULT);
   localparam int ICACHE_TAG_W = icache_tag_w(ICACHE_LINES_DEFAULT);

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WAIT_MEM = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/inst_fetcher_icache_dm.sv
// ---------------------------------------------------------------------------
// icache_dm
// Direct-mapped instruction cache, one 32-bit word per line.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears valid bits)
//   i_rd_idx      lookup line index
//   i_rd_tag      lookup tag
//   o_hit         line valid and tag matches (combinational)
//   o_rd_data     data word of the looked-up line (combinational)
//   i_wr_en       write strobe (fills a line, sets it valid)
//   i_wr_idx      line to fill
//   i_wr_tag      tag stored with the fill
//   i_wr_data     word stored with the fill
// ---------------------------------------------------------------------------
module icache_dm
   import inst_fetcher_pkg::*;
#(
   parameter int LINES = ICACHE_LINES_DEFAULT,
   parameter int IDX_W = icache_idx_w(LINES),
   parameter int TAG_W = icache_tag_w(LINES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IDX_W-1:0]      i_rd_idx,
   input  logic [TAG_W-1:0]      i_rd_tag,
   output logic                  o_hit,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   input  logic                  i_wr_en,
   input  logic [IDX_W-1:0]      i_wr_idx,
   input  logic [TAG_W-1:0]      i_wr_tag,
   input  logic [DATA_WIDTH-1:0] i_wr_data
);

   logic [LINES-1:0]      r_valid;
   logic [TAG_W-1:0]      r_tag  [LINES];
   logic [DATA_WIDTH-1:0] r_data [LINES];

   // Only the valid bits need clearing; stale tag/data are masked by them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
      end else if (i_wr_en) begin
         r_valid[i_wr_idx] <= TRUE;
      end
   end

   // Fills overwrite unconditionally: no replacement policy in a
   // direct-mapped cache, an aliasing address simply evicts the line.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_tag[i_wr_idx]  <= i_wr_tag;
         r_data[i_wr_idx] <= i_wr_data;
      end
   end

   assign o_hit     = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
   assign o_rd_data = r_data[i_rd_idx];

endmodule

// File: rtl/inst_fetcher.sv
// ---------------------------------------------------------------------------
// inst_fetcher
// Instruction fetch stage: holds the PC, looks it up in a direct-mapped
// instruction cache, requests missing words from the memory controller and
// emits one instruction per cycle toward decode. Redirects on ROB misbranch.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable; low freezes every register
//   out_mem_ce        one-cycle fetch request pulse
//   out_mem_addr      fetch address, held from request until done
//   in_mem_ce         one-cycle done pulse from the memory controller
//   in_mem_data       fetched word, valid with in_mem_ce
//   in_stall          downstream full; nothing may be emitted
//   out_inst_valid    one-cycle pulse qualifying out_inst / out_pc
//   out_inst          instruction word
//   out_pc            PC of out_inst
//   in_rob_misbranch  redirect request
//   in_rob_newpc      redirect target
// ---------------------------------------------------------------------------
module inst_fetcher
   import inst_fetcher_pkg::*;
#(
   parameter int          ICACHE_LINES = ICACHE_LINES_DEFAULT,
   parameter logic [31:0] RESET_PC     = 32'h0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   output logic                  out_mem_ce,
   output logic [DATA_WIDTH-1:0] out_mem_addr,
   input  logic                  in_mem_ce,
   input  logic [DATA_WIDTH-1:0] in_mem_data,
   input  logic                  in_stall,
   output logic                  out_inst_valid,
   output logic [DATA_WIDTH-1:0] out_inst,
   output logic [DATA_WIDTH-1:0] out_pc,
   input  logic                  in_rob_misbranch,
   input  logic [DATA_WIDTH-1:0] in_rob_newpc
);

   localparam int IDX_W = icache_idx_w(ICACHE_LINES);
   localparam int TAG_W = icache_tag_w(ICACHE_LINES);

   fetch_state_e          r_state;
   fetch_state_e          w_state_next;
   logic [DATA_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] w_pc_next;
   logic                  r_mem_ce;
   logic                  w_mem_ce_next;
   logic [DATA_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] w_mem_addr_next;
   logic                  r_inst_valid;
   logic                  w_inst_valid_next;
   logic [DATA_WIDTH-1:0] r_inst;
   logic [DATA_WIDTH-1:0] w_inst_next;
   logic [DATA_WIDTH-1:0] r_out_pc;
   logic [DATA_WIDTH-1:0] w_out_pc_next;

   logic                  w_fill;
   logic                  w_hit;
   logic [DATA_WIDTH-1:0] w_hit_data;
   logic [IDX_W-1:0]      w_idx;
   logic [TAG_W-1:0]      w_tag;

   // The PC does not move while a miss is outstanding, so the same index and
   // tag serve both the lookup and the fill.
   assign w_idx = r_pc[IDX_W+1:2];
   assign w_tag = r_pc[DATA_WIDTH-1:IDX_W+2];

   icache_dm #(
      .LINES (ICACHE_LINES),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_icache (
      .clk       (clk),
      .rst       (rst),
      .i_rd_idx  (w_idx),
      .i_rd_tag  (w_tag),
      .o_hit     (w_hit),
      .o_rd_data (w_hit_data),
      .i_wr_en   (w_fill && rdy),
      .i_wr_idx  (w_idx),
      .i_wr_tag  (w_tag),
      .i_wr_data (in_mem_data)
   );

   // Next-state and output logic. Both pulse outputs default low every
   // active cycle; a level on out_mem_ce would re-arm the memory controller.
   always_comb begin
      w_state_next      = r_state;
      w_pc_next         = r_pc;
      w_mem_ce_next     = FALSE;
      w_mem_addr_next   = r_mem_addr;
      w_inst_valid_next = FALSE;
      w_inst_next       = r_inst;
      w_out_pc_next     = r_out_pc;
      w_fill            = FALSE;

      if (in_rob_misbranch) begin
         // Abandon any outstanding request and drop a coincident done
         // pulse: the memory controller drops the request on the same
         // signal, and the word belongs to the wrong path anyway.
         w_pc_next    = in_rob_newpc;
         w_state_next = IDLE;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (!in_stall) begin
                  if (w_hit) begin
                     w_inst_valid_next = TRUE;
                     w_inst_next       = w_hit_data;
                     w_out_pc_next     = r_pc;
                     w_pc_next         = r_pc + 32'd4;
                  end else begin
                     w_mem_ce_next   = TRUE;
                     w_mem_addr_next = r_pc;
                     w_state_next    = WAIT_MEM;
                  end
               end
            end
            WAIT_MEM: begin
               if (in_mem_ce) begin
                  w_fill       = TRUE;
                  w_state_next = IDLE;
                  // Under stall only the fill happens; the next IDLE cycle
                  // hits on the freshly written line.
                  if (!in_stall) begin
                     w_inst_valid_next = TRUE;
                     w_inst_next       = in_mem_data;
                     w_out_pc_next     = r_pc;
                     w_pc_next         = r_pc + 32'd4;
                  end
               end
            end
            default: begin
               w_state_next = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_pc         <= RESET_PC;
         r_mem_ce     <= FALSE;
         r_mem_addr   <= ZERO_DATA;
         r_inst_valid <= FALSE;
         r_inst       <= ZERO_DATA;
         r_out_pc     <= ZERO_DATA;
      end else if (rdy) begin
         r_state      <= w_state_next;
         r_pc         <= w_pc_next;
         r_mem_ce     <= w_mem_ce_next;
         r_mem_addr   <= w_mem_addr_next;
         r_inst_valid <= w_inst_valid_next;
         r_inst       <= w_inst_next;
         r_out_pc     <= w_out_pc_next;
      end
   end

   assign out_mem_ce     = r_mem_ce;
   assign out_mem_addr   = r_mem_addr;
   assign out_inst_valid = r_inst_valid;
   assign out_inst       = r_inst;
   assign out_pc         = r_out_pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// ---------------------------------------------------------------------------
// tb_inst_fetcher
// Directed bench for inst_fetcher: cold-start miss, loop hits, aliasing,
// stall during miss, misbranch coinciding with done, rdy freeze and reset
// during an outstanding miss.
// ---------------------------------------------------------------------------
module tb_inst_fetcher;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        out_mem_ce;
   logic [31:0] out_mem_addr;
   logic        in_mem_ce;
   logic [31:0] in_mem_data;
   logic        in_stall;
   logic        out_inst_valid;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        in_rob_misbranch;
   logic [31:0] in_rob_newpc;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   inst_fetcher #(
      .ICACHE_LINES (256),
      .RESET_PC     (32'h0)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .rdy              (rdy),
      .out_mem_ce       (out_mem_ce),
      .out_mem_addr     (out_mem_addr),
      .in_mem_ce        (in_mem_ce),
      .in_mem_data      (in_mem_data),
      .in_stall         (in_stall),
      .out_inst_valid   (out_inst_valid),
      .out_inst         (out_inst),
      .out_pc           (out_pc),
      .in_rob_misbranch (in_rob_misbranch),
      .in_rob_newpc     (in_rob_newpc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Bounded wait for a request pulse, then check its address.
   task automatic wait_req(input string tag, input logic [31:0] addr);
      int n = 0;
      while (out_mem_ce !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check({tag, " req_pulse"}, {31'b0, out_mem_ce}, 32'd1);
      check({tag, " req_addr"}, out_mem_addr, addr);
   endtask

   // Serve one request: done pulse five cycles after the request pulse.
   task automatic do_miss(input string tag, input logic [31:0] addr,
                          input logic [31:0] data, input logic stall);
      int extra = 0;
      int moved = 0;
      wait_req(tag, addr);
      repeat (4) begin
         tick();
         if (out_mem_ce !== 1'b0) extra++;
         if (out_mem_addr !== addr) moved++;
      end
      check({tag, " extra_pulses"}, extra, 32'd0);
      check({tag, " addr_held"}, moved, 32'd0);
      in_stall    = stall;
      in_mem_ce   = 1'b1;
      in_mem_data = data;
      tick();
      in_mem_ce   = 1'b0;
      in_mem_data = 32'h0;
   endtask

   task automatic check_emit(input string tag, input logic [31:0] inst, input logic [31:0] pc);
      check({tag, " valid"}, {31'b0, out_inst_valid}, 32'd1);
      check({tag, " inst"}, out_inst, inst);
      check({tag, " pc"}, out_pc, pc);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " no_valid"}, {31'b0, out_inst_valid}, 32'd0);
      check({tag, " no_req"}, {31'b0, out_mem_ce}, 32'd0);
   endtask

   task automatic redirect(input logic [31:0] newpc);
      in_rob_misbranch = 1'b1;
      in_rob_newpc     = newpc;
      tick();
      in_rob_misbranch = 1'b0;
      in_rob_newpc     = 32'h0;
   endtask

   initial begin
      int held;
      rst = 1'b1; rdy = 1'b1; in_mem_ce = 1'b0; in_mem_data = 32'h0;
      in_stall = 1'b0; in_rob_misbranch = 1'b0; in_rob_newpc = 32'h0;
      repeat (3) tick();
      check("reset mem_ce", {31'b0, out_mem_ce}, 32'd0);
      check("reset mem_addr", out_mem_addr, 32'h0);
      check("reset inst_valid", {31'b0, out_inst_valid}, 32'd0);
      check("reset inst", out_inst, 32'h0);
      check("reset pc", out_pc, 32'h0);
      rst = 1'b0;

      // Cold start: fill 0, 4, 8.
      do_miss("cold0", 32'h0, 32'h0000_0013, 1'b0);
      check_emit("cold0 emit", 32'h0000_0013, 32'h0);
      do_miss("cold4", 32'h4, 32'h0010_0093, 1'b0);
      check_emit("cold4 emit", 32'h0010_0093, 32'h4);
      do_miss("cold8", 32'h8, 32'h0020_0113, 1'b0);
      check_emit("cold8 emit", 32'h0020_0113, 32'h8);

      // Loop back to 0: three back-to-back hits, no requests.
      redirect(32'h0);
      check_quiet("redir0");
      tick();
      check_emit("hit0", 32'h0000_0013, 32'h0);
      check("hit0 no_req", {31'b0, out_mem_ce}, 32'd0);
      tick();
      check_emit("hit4", 32'h0010_0093, 32'h4);
      check("hit4 no_req", {31'b0, out_mem_ce}, 32'd0);
      tick();
      check_emit("hit8", 32'h0020_0113, 32'h8);
      check("hit8 no_req", {31'b0, out_mem_ce}, 32'd0);

      // Alias: 0x400 shares line 0 with 0x000 and evicts it.
      redirect(32'h400);
      do_miss("alias400", 32'h400, 32'hDEAD_BEEF, 1'b0);
      check_emit("alias400 emit", 32'hDEAD_BEEF, 32'h400);
      redirect(32'h0);

      // 0x000 misses again; done arrives under stall -> fill only.
      do_miss("stall0", 32'h0, 32'h0000_0013, 1'b1);
      check_quiet("stall0 done");
      tick();
      check_quiet("stall0 hold");
      in_stall = 1'b0;
      tick();
      check_emit("stall0 hit", 32'h0000_0013, 32'h0);
      check("stall0 hit no_req", {31'b0, out_mem_ce}, 32'd0);

      // Misbranch coinciding with done: no fill, no emit.
      redirect(32'h40);
      wait_req("mb40", 32'h40);
      repeat (4) tick();
      in_mem_ce = 1'b1; in_mem_data = 32'h0BAD_0BAD;
      in_rob_misbranch = 1'b1; in_rob_newpc = 32'h100;
      tick();
      in_mem_ce = 1'b0; in_mem_data = 32'h0;
      in_rob_misbranch = 1'b0; in_rob_newpc = 32'h0;
      check_quiet("mb40 done");
      do_miss("mb100", 32'h100, 32'h0000_0113, 1'b0);
      check_emit("mb100 emit", 32'h0000_0113, 32'h100);
      // 0x40 was never filled, so it must miss.
      redirect(32'h40);
      wait_req("refetch40", 32'h40);

      // rdy low for three cycles with the request pulse showing: frozen.
      rdy = 1'b0;
      held = 0;
      repeat (3) begin
         tick();
         if (out_mem_ce !== 1'b1 || out_mem_addr !== 32'h40 ||
             out_inst_valid !== 1'b1 - 1'b1 || out_pc !== 32'h100)
            held++;
      end
      check("rdy0 frozen", held, 32'd0);
      rdy = 1'b1;
      tick();
      check("rdy1 pulse_ends", {31'b0, out_mem_ce}, 32'd0);
      check("rdy1 addr_held", out_mem_addr, 32'h40);

      // Reset while waiting on memory.
      rst = 1'b1;
      tick();
      check("rst mem_ce", {31'b0, out_mem_ce}, 32'd0);
      check("rst mem_addr", out_mem_addr, 32'h0);
      check("rst inst_valid", {31'b0, out_inst_valid}, 32'd0);
      check("rst inst", out_inst, 32'h0);
      check("rst pc", out_pc, 32'h0);
      rst = 1'b0;
      // Valid bits cleared: 0x000 misses despite the earlier fill.
      do_miss("postrst", 32'h0, 32'h0000_0033, 1'b0);
      check_emit("postrst emit", 32'h0000_0033, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
